// File: rtl/gmii_axi_pkg.sv
// Shared types for the GMII receive to AXI4-Stream bridge: the FIFO word layout,
// the write-side packer states and the byte-enable helper.
package gmii_axi_pkg;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
        logic              user;
    } axis_word_t;

    localparam int WORD_W = $bits(axis_word_t);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_DROP = 2'd2,
        ST_TERM = 2'd3
    } wr_state_e;

    // Marks a frame cut short by overflow so downstream sees an errored end.
    localparam axis_word_t TERM_WORD = '{data: 64'd0, keep: 8'h01, last: 1'b1, user: 1'b1};

    function automatic logic [KEEP_W-1:0] keep_from_count(input logic [3:0] count);
        logic [KEEP_W-1:0] keep;
        keep = {KEEP_W{1'b0}};
        for (int k = 0; k < KEEP_W; k++) begin
            keep[k] = (4'(k) < count);
        end
        return keep;
    endfunction

endpackage

// File: rtl/gmii_rx_async_fifo.sv
// Dual-clock FIFO with gray-coded pointers and two-flop synchronizers in each direction.
// Full is declared one entry early so the FIFO plus the downstream output register hold DEPTH words.
module gmii_rx_async_fifo #(
    parameter int WIDTH = 74,
    parameter int DEPTH = 16
) (
    input  logic             rst_n,
    input  logic             wr_clk_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             full_o,
    input  logic             rd_clk_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_bin_q, wr_bin_d, wr_gray_q;
    logic [PW-1:0] rd_gray_m_q, rd_gray_s_q;
    logic [PW-1:0] rd_bin_q, rd_bin_d, rd_gray_q;
    logic [PW-1:0] wr_gray_m_q, wr_gray_s_q;
    logic [PW-1:0] used_s;
    logic          wr_do_s, rd_do_s;

    // Write side: occupancy against the synchronized read pointer.
    always_comb begin
        used_s   = wr_bin_q - gray2bin(rd_gray_s_q);
        full_o   = (used_s >= PW'(DEPTH - 1));
        wr_do_s  = wr_en_i && !full_o;
        if (wr_do_s) begin
            wr_bin_d = wr_bin_q + PW'(1);
        end else begin
            wr_bin_d = wr_bin_q;
        end
    end

    // Write pointer registers and read-pointer synchronizer.
    always_ff @(posedge wr_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_bin_q    <= {PW{1'b0}};
            wr_gray_q   <= {PW{1'b0}};
            rd_gray_m_q <= {PW{1'b0}};
            rd_gray_s_q <= {PW{1'b0}};
        end else begin
            wr_bin_q    <= wr_bin_d;
            wr_gray_q   <= bin2gray(wr_bin_d);
            rd_gray_m_q <= rd_gray_q;
            rd_gray_s_q <= rd_gray_m_q;
        end
    end

    // Storage array write port.
    always_ff @(posedge wr_clk_i) begin
        if (wr_do_s) begin
            mem_q[wr_bin_q[AW-1:0]] <= wr_data_i;
        end
    end

    // Read side: empty when the synchronized write pointer matches ours.
    always_comb begin
        empty_o   = (rd_gray_q == wr_gray_s_q);
        rd_do_s   = rd_en_i && !empty_o;
        rd_data_o = mem_q[rd_bin_q[AW-1:0]];
        if (rd_do_s) begin
            rd_bin_d = rd_bin_q + PW'(1);
        end else begin
            rd_bin_d = rd_bin_q;
        end
    end

    // Read pointer registers and write-pointer synchronizer.
    always_ff @(posedge rd_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rd_bin_q    <= {PW{1'b0}};
            rd_gray_q   <= {PW{1'b0}};
            wr_gray_m_q <= {PW{1'b0}};
            wr_gray_s_q <= {PW{1'b0}};
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= bin2gray(rd_bin_d);
            wr_gray_m_q <= wr_gray_q;
            wr_gray_s_q <= wr_gray_m_q;
        end
    end

endmodule

// File: rtl/gmii_to_axi.sv
// GMII receive bytes packed little-endian into 64-bit words, carried across to tx_clk_out
// through an async FIFO and presented as an AXI4-Stream master with a registered output stage.
module gmii_to_axi
    import gmii_axi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        rst_n,
    input  logic        tx_clk_out,
    input  logic        gmii_rx_clk,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        rx_frame_dropped
);

    wr_state_e   state_q, state_d;
    logic [63:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        dv_prev_q;
    logic        drop_q, drop_d;
    logic [63:0] byte_s;
    logic        need_wr_s;
    logic        wr_en_s, fifo_full_s;
    axis_word_t  wr_word_s;

    logic        rd_en_s, fifo_empty_s;
    axis_word_t  rd_word_s;
    axis_word_t  out_q;
    logic        out_valid_q;

    // Packer next-state: a word is pushed when a held full word meets another byte or when dv drops.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        drop_d    = 1'b0;
        wr_en_s   = 1'b0;
        wr_word_s = '{data: buf_q, keep: keep_from_count(cnt_q),
                      last: !gmii_rx_dv, user: !gmii_rx_dv && err_q};
        byte_s    = {56'd0, gmii_rxd} << {cnt_q[2:0], 3'b000};
        need_wr_s = !gmii_rx_dv || (cnt_q == 4'd8);
        case (state_q)
            ST_IDLE: begin
                // A frame is only accepted from its first byte, never joined mid-way.
                if (gmii_rx_dv && !dv_prev_q) begin
                    buf_d   = {56'd0, gmii_rxd};
                    cnt_d   = 4'd1;
                    err_d   = gmii_rx_er;
                    state_d = ST_PACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PACK: begin
                if (need_wr_s && fifo_full_s) begin
                    drop_d  = 1'b1;
                    state_d = gmii_rx_dv ? ST_DROP : ST_TERM;
                end else if (need_wr_s) begin
                    wr_en_s = 1'b1;
                    if (gmii_rx_dv) begin
                        buf_d = {56'd0, gmii_rxd};
                        cnt_d = 4'd1;
                        err_d = err_q | gmii_rx_er;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    buf_d = buf_q | byte_s;
                    cnt_d = cnt_q + 4'd1;
                    err_d = err_q | gmii_rx_er;
                end
            end
            ST_DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = ST_TERM;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_TERM: begin
                wr_word_s = TERM_WORD;
                if (!fifo_full_s) begin
                    wr_en_s = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_TERM;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Packer state registers; dv_prev resets high so a frame in flight at reset release is skipped.
    always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            buf_q     <= 64'd0;
            cnt_q     <= 4'd0;
            err_q     <= 1'b0;
            dv_prev_q <= 1'b1;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            dv_prev_q <= gmii_rx_dv;
            drop_q    <= drop_d;
        end
    end

    gmii_rx_async_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .rst_n     (rst_n),
        .wr_clk_i  (gmii_rx_clk),
        .wr_en_i   (wr_en_s),
        .wr_data_i (wr_word_s),
        .full_o    (fifo_full_s),
        .rd_clk_i  (tx_clk_out),
        .rd_en_i   (rd_en_s),
        .rd_data_o (rd_word_s),
        .empty_o   (fifo_empty_s)
    );

    // Refill the output stage whenever it is empty or being consumed this cycle.
    always_comb begin
        rd_en_s = !fifo_empty_s && (!out_valid_q || m_axis_tready);
    end

    // AXI output register: holds the word stable until the handshake.
    always_ff @(posedge tx_clk_out or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '{data: 64'd0, keep: 8'h00, last: 1'b0, user: 1'b0};
            out_valid_q <= 1'b0;
        end else if (rd_en_s) begin
            out_q       <= rd_word_s;
            out_valid_q <= 1'b1;
        end else if (m_axis_tready) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_q;
        end
    end

    assign m_axis_tvalid    = out_valid_q;
    assign m_axis_tdata     = out_q.data;
    assign m_axis_tkeep     = out_q.keep;
    assign m_axis_tlast     = out_q.last;
    assign m_axis_tuser     = out_q.user;
    assign rx_frame_dropped = drop_q;

endmodule

// File: tb/tb_gmii_to_axi.sv
// Self-checking bench for gmii_to_axi: random GMII frames compared against a frame-level
// reference model of the expected AXI word stream.
`timescale 1ns/100ps
module tb_gmii_to_axi;

    localparam int DEPTH = 16;

    logic        rst_n;
    logic        tx_clk_out  = 1'b0;
    logic        gmii_rx_clk = 1'b0;
    logic        gmii_rx_dv, gmii_rx_er;
    logic [7:0]  gmii_rxd;
    logic        m_axis_tvalid, m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tlast, m_axis_tuser, rx_frame_dropped;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;
    int drop_pulses = 0;

    logic [7:0]  fr_b [0:2047];
    logic        fr_e [0:2047];
    logic [73:0] exp_q [$];
    logic [73:0] got_q [$];

    gmii_to_axi #(.FIFO_DEPTH(DEPTH)) dut (
        .rst_n            (rst_n),
        .tx_clk_out       (tx_clk_out),
        .gmii_rx_clk      (gmii_rx_clk),
        .gmii_rx_dv       (gmii_rx_dv),
        .gmii_rx_er       (gmii_rx_er),
        .gmii_rxd         (gmii_rxd),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tkeep     (m_axis_tkeep),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_tuser     (m_axis_tuser),
        .rx_frame_dropped (rx_frame_dropped)
    );

    always #3.2 tx_clk_out  = ~tx_clk_out;
    always #4   gmii_rx_clk = ~gmii_rx_clk;

    // Capture accepted words away from the active edge.
    always @(negedge tx_clk_out) begin
        if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1)
            got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser});
    end

    always @(negedge gmii_rx_clk) begin
        if (rx_frame_dropped === 1'b1) drop_pulses++;
    end

    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge tx_clk_out);
            #1;
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic fill_random(input int len, input int err_one_in);
        for (int i = 0; i < len; i++) begin
            fr_b[i] = 8'($urandom_range(0, 255));
            fr_e[i] = (err_one_in > 0) ? ($urandom_range(1, err_one_in) == 1) : 1'b0;
        end
    endtask

    // Reference: split the frame into 8-byte groups; truncate to max_words plus a terminator.
    task automatic model_frame(input int len, input int max_words);
        int          nw;
        logic        any_err;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        any_err = 1'b0;
        for (int i = 0; i < len; i++) any_err = any_err | fr_e[i];
        nw = (len + 7) / 8;
        for (int w = 0; w < nw; w++) begin
            if (w == max_words) begin
                exp_q.push_back({64'd0, 8'h01, 1'b1, 1'b1});
                return;
            end
            data = 64'd0;
            keep = 8'h00;
            for (int k = 0; k < 8; k++) begin
                if (w * 8 + k < len) begin
                    data[8*k +: 8] = fr_b[w*8 + k];
                    keep[k] = 1'b1;
                end
            end
            last = (w == nw - 1);
            exp_q.push_back({data, keep, last, last & any_err});
        end
    endtask

    task automatic send_frame(input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            @(negedge gmii_rx_clk);
            gmii_rx_dv = 1'b1; gmii_rxd = fr_b[i]; gmii_rx_er = fr_e[i];
        end
        @(negedge gmii_rx_clk);
        gmii_rx_dv = 1'b0; gmii_rxd = 8'h00; gmii_rx_er = 1'b0;
        repeat (gap - 1) @(negedge gmii_rx_clk);
    endtask

    task automatic collect(input int n, output bit ok);
        int cyc;
        cyc = 0;
        while (got_q.size() < n && cyc < 6000) begin
            @(negedge tx_clk_out);
            cyc++;
        end
        ok = (got_q.size() >= n);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; gmii_rx_dv = 1'b0; gmii_rx_er = 1'b0; gmii_rxd = 8'h00;
        #50;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'd0 || m_axis_tkeep !== 8'h00 ||
            m_axis_tlast !== 1'b0 || m_axis_tuser !== 1'b0 || rx_frame_dropped !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: got valid=%b data=%h keep=%h last=%b user=%b drop=%b, expected all zero",
                     m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser, rx_frame_dropped);
        end
        @(negedge gmii_rx_clk);
        rst_n = 1'b1;
        repeat (10) @(negedge tx_clk_out);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: tvalid=%b, expected 0", m_axis_tvalid);
        end
    endtask

    task automatic test_frame64;
        bit ok;
        logic [73:0] e, g;
        ready_mode = 0;
        for (int i = 0; i < 64; i++) begin fr_b[i] = 8'(i); fr_e[i] = 1'b0; end
        model_frame(64, 1000);
        send_frame(64, 4);
        collect(exp_q.size(), ok);
        checks++;
        if (!ok || got_q[0][73:2] !== {64'h0706050403020100, 8'hFF}) begin
            errors++;
            $display("FAIL frame64_word0: got %0d words, first %h, expected data 0706050403020100 keep ff",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 74'd0);
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL frame64_word: got %h expected %h", g, e); end
        end
        repeat (30) @(negedge tx_clk_out);
        checks++;
        if (got_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL frame64_count: %0d extra, %0d missing words, expected 0 and 0", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_single_and_error;
        bit ok;
        logic [73:0] e, g;
        fr_b[0] = 8'hAB; fr_e[0] = 1'b0;
        model_frame(1, 1000);
        send_frame(1, 3);
        fill_random(13, 0);
        fr_e[5] = 1'b1;
        model_frame(13, 1000);
        send_frame(13, 3);
        collect(3, ok);
        checks++;
        if (!ok || got_q[0] !== {64'h00000000000000AB, 8'h01, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL single_byte: got %0d words, first %h, expected %h", got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 74'd0, {64'hAB, 8'h01, 1'b1, 1'b0});
        end
        checks++;
        if (!ok || got_q[2][9:0] !== {8'h1F, 1'b1, 1'b1} || got_q[1][0] !== 1'b0) begin
            errors++;
            $display("FAIL err_frame_tags: got w0 user=%b w1 keep/last/user=%h, expected 0 and 07f",
                     (got_q.size() > 1) ? got_q[1][0] : 1'bx, (got_q.size() > 2) ? got_q[2][9:0] : 10'd0);
        end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL single_err_word: got %h expected %h", g, e); end
        end
        repeat (30) @(negedge tx_clk_out);
        checks++;
        if (got_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_err_count: %0d extra, %0d missing words, expected 0 and 0", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back;
        bit ok;
        logic [73:0] e, g;
        fill_random(8, 0);
        model_frame(8, 1000);
        send_frame(8, 1);
        fill_random(9, 0);
        model_frame(9, 1000);
        send_frame(9, 3);
        collect(exp_q.size(), ok);
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_word: got %h expected %h", g, e); end
        end
        repeat (30) @(negedge tx_clk_out);
        checks++;
        if (!ok || got_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: %0d extra, %0d missing words, expected 0 and 0", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random;
        bit ok;
        int len;
        logic [73:0] e, g;
        ready_mode = 1;
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 100);
            fill_random(len, 64);
            model_frame(len, 1000);
            send_frame(len, $urandom_range(1, 5));
        end
        collect(exp_q.size(), ok);
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL random_word: got %h expected %h", g, e); end
        end
        repeat (60) @(negedge tx_clk_out);
        checks++;
        if (!ok || got_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_count: %0d extra, %0d missing words, expected 0 and 0", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
        ready_mode = 0;
    endtask

    task automatic test_overflow;
        bit ok;
        int drops_before;
        logic [73:0] first_w, e, g;
        ready_mode = 2;
        repeat (4) @(negedge tx_clk_out);
        drops_before = drop_pulses;
        fill_random(1518, 0);
        model_frame(1518, DEPTH);
        send_frame(1518, 4);
        @(negedge tx_clk_out);
        first_w = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        for (int i = 0; i < 6; i++) begin
            @(negedge tx_clk_out);
            checks++;
            if (m_axis_tvalid !== 1'b1 || {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== first_w) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b word=%h, expected valid=1 word=%h", m_axis_tvalid,
                         {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, first_w);
            end
        end
        checks++;
        if (drop_pulses - drops_before != 1) begin
            errors++;
            $display("FAIL drop_pulse: got %0d pulse cycles, expected 1", drop_pulses - drops_before);
        end
        ready_mode = 0;
        repeat (50) @(negedge gmii_rx_clk);
        fill_random(60, 0);
        model_frame(60, 1000);
        send_frame(60, 4);
        collect(exp_q.size(), ok);
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL overflow_word: got %h expected %h", g, e); end
        end
        repeat (30) @(negedge tx_clk_out);
        checks++;
        if (!ok || got_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_count: %0d extra, %0d missing words, expected 0 and 0", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midframe;
        bit ok;
        logic [73:0] e, g;
        fill_random(20, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge gmii_rx_clk);
            gmii_rx_dv = 1'b1; gmii_rxd = fr_b[i]; gmii_rx_er = 1'b0;
        end
        rst_n = 1'b0;
        for (int i = 6; i < 9; i++) begin
            @(negedge gmii_rx_clk);
            gmii_rxd = fr_b[i];
        end
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tkeep !== 8'h00) begin
            errors++;
            $display("FAIL midreset_outputs: got valid=%b keep=%h, expected 0 and 00", m_axis_tvalid, m_axis_tkeep);
        end
        rst_n = 1'b1;
        for (int i = 9; i < 20; i++) begin
            @(negedge gmii_rx_clk);
            gmii_rxd = fr_b[i];
        end
        @(negedge gmii_rx_clk);
        gmii_rx_dv = 1'b0; gmii_rxd = 8'h00;
        repeat (3) @(negedge gmii_rx_clk);
        fill_random(27, 16);
        model_frame(27, 1000);
        send_frame(27, 4);
        collect(exp_q.size(), ok);
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL midreset_word: got %h expected %h", g, e); end
        end
        repeat (30) @(negedge tx_clk_out);
        checks++;
        if (!ok || got_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_count: %0d extra, %0d missing words, expected 0 and 0", got_q.size(), exp_q.size());
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_frame64();
        test_single_and_error();
        test_back_to_back();
        test_random();
        test_overflow();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gmii_to_axi.md
# gmii_to_axi

Receive-direction bridge: accepts byte-wide GMII receive data at 125 MHz (gmii_rx_clk), packs bytes little-endian into 64-bit words with byte-enable, last and error tagging, and crosses into the 156.25 MHz tx_clk_out domain through a small asynchronous FIFO. It presents the words as an AXI4-Stream master with tready backpressure. It is the counterpart of the existing AXI-to-GMII transmit bridge and sits between the 1G RGMII/GMII PHY front end and the 10G SFP MAC transmit path.

## Interface
- FIFO_DEPTH, 16, entries in the CDC FIFO (power of 2, ≥8)
- rst_n  input  1  reset rst_n, asynchronous, active-low; resets both clock domains
- tx_clk_out  input  1  clock tx_clk_out; AXI output domain (156.25 MHz)
- gmii_rx_clk  input  1  GMII input domain (125 MHz)
- gmii_rx_dv  input  1  GMII receive data valid
- gmii_rx_er  input  1  GMII receive error
- gmii_rxd  input  8  GMII receive byte
- m_axis_tvalid  output  1  output word valid
- m_axis_tready  input  1  downstream ready
- m_axis_tdata  output  64  packed bytes, first byte in [7:0]
- m_axis_tkeep  output  8  byte enables, contiguous from bit 0
- m_axis_tlast  output  1  last word of frame
- m_axis_tuser  output  1  frame error, valid only with tlast
- rx_frame_dropped  output  1  one-cycle pulse (gmii_rx_clk) when a frame is truncated by overflow

## Operation
- Bytes forwarded verbatim: preamble/SFD not stripped, no FCS check.
- Frame = maximal run of cycles with gmii_rx_dv=1; one low cycle ends the frame.
- Packer (gmii_rx_clk): byte index 0..7; byte k goes to data[8k+7:8k], keep[k]=1. gmii_rx_er during any byte of the frame sets sticky err flag for the frame.
- Full word (8 bytes) held one cycle: if next cycle dv=1, written with last=0; if dv=0, written with last=1, user=err.
- Partial word on dv falling: written with last=1, keep=(1<<n)-1, user=err, unused data bytes zero.
- Write-side states: IDLE, PACK, DROP, TERM.
  - IDLE→PACK on dv=1.
  - PACK→IDLE after writing last word.
  - PACK→DROP if a word must be written while FIFO full; rx_frame_dropped pulses; bytes discarded.
  - DROP→TERM when dv falls; TERM writes terminator word data=0, keep=8'h01, last=1, user=1 once FIFO not full, then →IDLE. New frames arriving in TERM/DROP are discarded entirely.
- FIFO: gray-coded pointers, 2-flop synchronizers each way, full/empty from synchronized pointers (conservative).
- Output: registered stage; tvalid stays high and tdata/tkeep/tlast/tuser stable until tready=1. Next word loaded same cycle as handshake if available (full throughput).

## Timing
- Reset values: m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, rx_frame_dropped=0; FIFO empty; packer IDLE.
- Write latency: last byte of frame at GMII edge N → FIFO write at gmii_rx_clk edge N+1.
- Read latency: FIFO write → m_axis_tvalid within 4 tx_clk_out cycles (2 sync + read + output reg).
- Output bandwidth exceeds input; overflow only under sustained tready=0.
- Reset mid-frame: all state cleared immediately; bytes of current frame lost; after deassert, packer waits for dv=0 before accepting next frame (no partial-frame start).
- FIFO pointer wrap at FIFO_DEPTH with extra MSB for full/empty.

## Structure
- Package gmii_axi_pkg: DATA_W=64, KEEP_W=8, word struct {data, keep, last, user} (74 bits), write-state enum.
- Sub-module gmii_rx_async_fifo (74-bit, FIFO_DEPTH, gray pointers, sync stages); top holds packer FSM and output register.

## Test plan
- 64-byte frame 0x00..0x3F, tready=1 → 8 words, word0 tdata=64'h0706050403020100, keep 8'hFF, tlast only on word 7, tuser=0.
- 1-byte frame 0xAB → single word tdata=64'hAB, keep 8'h01, tlast=1.
- 13-byte frame with gmii_rx_er on byte 5 → word1 keep 8'h1F, tlast=1, tuser=1; word0 tuser=0.
- Two frames separated by one dv-low cycle (8 and 9 bytes) → words keep FF/last; FF, 01/last; no merging.
- tready=0 for full 1518-byte frame with FIFO_DEPTH=16 → rx_frame_dropped pulses once; after tready=1, 16 words then terminator keep 8'h01, tlast=1, tuser=1; next frame intact.
- rst_n asserted mid-frame, released while dv=1 → no output for that frame; next frame output correct.
